axis_mux_n: RTL

- Parametrised N:1 AXI-Stream multiplexer with packet-aware switching.
- The channel is chosen only at packet boundaries, either by external sel or by a round-robin arbiter.
- Once chosen, the channel is locked until its TLAST beat transfers.
- Output is a single registered stage with full throughput and correct backpressure. It sits between multiple byte-stream sources and one downstream AXI-Stream consumer.

---
 rtl/axis_mux_n_if.sv | 22 ++
 rtl/axis_mux_n.sv | 105 ++++++++++
 2 files changed

// File: rtl/axis_mux_n_if.sv
// axis_mux_n_if: N slave AXI-Stream channels plus one master AXI-Stream channel
interface axis_mux_n_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
);
  logic [NUM_CH*DATA_W-1:0] s_axis_data;
  logic [NUM_CH-1:0]        s_axis_valid;
  logic [NUM_CH-1:0]        s_axis_last;
  logic [NUM_CH-1:0]        s_axis_ready;
  logic [DATA_W-1:0]        m_axis_data;
  logic                     m_axis_valid;
  logic                     m_axis_last;
  logic                     m_axis_ready;
  modport master (
    input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last
  );
  modport slave (
    output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last
  );
endinterface

// File: rtl/axis_mux_n.sv
// axis_mux_n: packet-aware N:1 AXI-Stream multiplexer with a registered output stage
module axis_mux_n #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ARB_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  axis_mux_n_if.master     bus,
  input  logic [SEL_W-1:0] sel_i,
  output logic [SEL_W-1:0] active_ch_o,
  output logic             busy_o
);
  typedef enum logic {IDLE, PASS} state_t;
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  active_q, active_d, ptr_q, ptr_d, grant_ch;
  logic [DATA_W-1:0] data_q, data_d, in_data;
  logic              valid_q, valid_d, last_q, last_d;
  logic              in_last, grant, accept, out_free;
  logic [NUM_CH-1:0] ready;

  // Grant candidate: the requested channel, or the first valid channel after the pointer
  always_comb begin
    grant    = 1'b0;
    grant_ch = '0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++)
        if (bus.s_axis_valid[i] && sel_i == SEL_W'(i)) begin
          grant    = 1'b1;
          grant_ch = SEL_W'(i);
        end
    end else begin
      for (int k = NUM_CH; k >= 1; k--)
        for (int i = 0; i < NUM_CH; i++)
          if (bus.s_axis_valid[i] && i == (int'(ptr_q) + k) % NUM_CH) begin
            grant    = 1'b1;
            grant_ch = SEL_W'(i);
          end
    end
  end

  // Ready only on the locked channel, and only when the output register can take a beat
  always_comb begin
    out_free = !valid_q || bus.m_axis_ready;
    ready    = '0;
    in_data  = '0;
    in_last  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ready[i] = (state_q == PASS) && out_free && (active_q == SEL_W'(i));
      if (active_q == SEL_W'(i)) begin
        in_data = bus.s_axis_data[i*DATA_W +: DATA_W];
        in_last = bus.s_axis_last[i];
      end
    end
    accept = |(ready & bus.s_axis_valid);
  end

  // Next state: grant at a packet boundary, load the output on accept, unlock on TLAST
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q && !bus.m_axis_ready;
    data_d   = data_q;
    last_d   = last_q;
    if (state_q == IDLE && grant) begin
      state_d  = PASS;
      active_d = grant_ch;
      ptr_d    = (ARB_MODE != 0) ? grant_ch : ptr_q;
    end
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
      state_d = in_last ? IDLE : state_d;
    end
  end

  // State and output registers; reset drops any beat in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      active_q <= '0;
      ptr_q    <= SEL_W'(NUM_CH - 1);
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign bus.s_axis_ready = ready;
  assign bus.m_axis_data  = data_q;
  assign bus.m_axis_valid = valid_q;
  assign bus.m_axis_last  = last_q;
  assign active_ch_o      = active_q;
  assign busy_o           = (state_q == PASS);
endmodule
